// File: rtl/spi_pkg.sv
// Shared SPI link definitions: responder state encoding and byte width.
package spi_pkg;
  localparam int SPI_BYTE_BITS = 8;

  typedef enum logic [1:0] {
    SPI_IDLE  = 2'd0,
    SPI_LOAD  = 2'd1,
    SPI_SHIFT = 2'd2
  } spi_resp_state_t;
endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer with a selectable reset value so idle levels are
// correct immediately after reset.
module spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rst_val,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (!rst_n) chain <= {STAGES{rst_val}};
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];
endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder with oversampled sck/cs/mosi and a one-byte tx holding register.
// Define SPI_RESP_UNDERRUN_EN to add the tx_underrun pulse and underrun_cnt counter.
//
// state     | meaning
// SPI_IDLE  | cs high, waiting for cs fall
// SPI_LOAD  | one clk: move holding (or fill) byte into shifter, drive MSB
// SPI_SHIFT | sample mosi on sck rise, advance miso on sck fall
module spi_responder
  import spi_pkg::*;
#(
  parameter logic [7:0] FILL_BYTE   = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       cs,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
`ifdef SPI_RESP_UNDERRUN_EN
  output logic       tx_underrun,
  output logic [7:0] underrun_cnt,
`endif
  output logic       busy
);
  localparam logic [2:0] LAST_BIT = 3'(SPI_BYTE_BITS - 1);

  spi_resp_state_t state, state_nxt;

  logic                     sck_s, cs_s, mosi_s;
  logic                     sck_d, cs_d;
  logic                     sck_rise, sck_fall, cs_rise, cs_fall;
  logic [2:0]               bit_cnt;
  logic [SPI_BYTE_BITS-2:0] tx_shift;
  logic [SPI_BYTE_BITS-2:0] rx_shift;
  logic [7:0]               holding;
  logic                     hold_full;
  logic [7:0]               load_byte;
  logic                     last_rise;

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .rst_val(1'b0), .d(sck), .q(sck_s));
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .rst_val(1'b1), .d(cs), .q(cs_s));
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .rst_val(1'b0), .d(mosi), .q(mosi_s));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_d <= 1'b0;
      cs_d  <= 1'b1;
    end else begin
      sck_d <= sck_s;
      cs_d  <= cs_s;
    end
  end

  assign sck_rise  = sck_s & ~sck_d;
  assign sck_fall  = ~sck_s & sck_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign last_rise = (state == SPI_SHIFT) && sck_rise && (bit_cnt == LAST_BIT);
  assign load_byte = hold_full ? holding : FILL_BYTE;
  assign tx_ready  = ~hold_full;
  assign busy      = (state != SPI_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= SPI_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SPI_IDLE:  if (cs_fall) state_nxt = SPI_LOAD;
      SPI_LOAD:  state_nxt = SPI_SHIFT;
      SPI_SHIFT: if (last_rise) state_nxt = SPI_LOAD;
      default:   state_nxt = SPI_IDLE;
    endcase
    if (cs_rise) state_nxt = SPI_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      bit_cnt   <= 3'd0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      holding   <= 8'h00;
      hold_full <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state == SPI_LOAD && hold_full) hold_full <= 1'b0;
      else if (tx_valid && !hold_full) begin
        holding   <= tx_data;
        hold_full <= 1'b1;
      end
      case (state)
        SPI_LOAD: begin
          tx_shift <= load_byte[SPI_BYTE_BITS-2:0];
          miso     <= load_byte[SPI_BYTE_BITS-1];
          miso_oe  <= 1'b1;
        end
        SPI_SHIFT: begin
          if (sck_rise) begin
            rx_shift <= {rx_shift[SPI_BYTE_BITS-3:0], mosi_s};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) begin
              rx_data  <= {rx_shift, mosi_s};
              rx_valid <= 1'b1;
            end
          // the fall after the 8th rise belongs to the finished byte; the new MSB is already out
          end else if (sck_fall && bit_cnt != 3'd0) begin
            miso     <= tx_shift[SPI_BYTE_BITS-2];
            tx_shift <= {tx_shift[SPI_BYTE_BITS-3:0], 1'b0};
          end
        end
        default: ;
      endcase
      if (cs_rise) begin
        bit_cnt <= 3'd0;
        miso_oe <= 1'b0;
      end
    end
  end

`ifdef SPI_RESP_UNDERRUN_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_underrun  <= 1'b0;
      underrun_cnt <= 8'h00;
    end else begin
      tx_underrun <= (state == SPI_LOAD) && !hold_full;
      if (state == SPI_LOAD && !hold_full && underrun_cnt != 8'hFF)
        underrun_cnt <= underrun_cnt + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_spi_responder.sv
// Scoreboard bench for spi_responder: expected miso/rx bytes queued at stimulus time.
module tb_spi_responder;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n, sck, cs, mosi, miso, miso_oe;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, busy;
`ifdef SPI_RESP_UNDERRUN_EN
  logic       tx_underrun;
  logic [7:0] underrun_cnt;
  int         ur_pulses = 0;
`endif

  int checks = 0, errors = 0, rx_cnt = 0;
  int half = 8;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];

  spi_responder #(.FILL_BYTE(8'hFF), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .cs(cs), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
`ifdef SPI_RESP_UNDERRUN_EN
    .tx_underrun(tx_underrun), .underrun_cnt(underrun_cnt),
`endif
    .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && rx_valid === 1'b1) begin
      rx_cnt++;
      if (exp_rx.size() == 0) chk("rx_extra", exp_rx.size(), 1);
      else                    chk("rx_data", rx_data, exp_rx.pop_front());
    end
`ifdef SPI_RESP_UNDERRUN_EN
    if (rst_n === 1'b1 && tx_underrun === 1'b1) ur_pulses++;
`endif
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_tx(input logic [7:0] b);
    int n = 0;
    while (tx_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("tx_ready_wait", n, 0);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] mo);
    logic [7:0] mi;
    mi = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      mosi = mo[i];
      repeat (half) @(negedge clk);
      mi[i] = miso;
      sck = 1'b1;
      repeat (half) @(negedge clk);
      sck = 1'b0;
    end
    if (exp_miso.size() == 0) chk("miso_extra", exp_miso.size(), 1);
    else                      chk("miso_byte", mi, exp_miso.pop_front());
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      mosi = i[0];
      repeat (half) @(negedge clk);
      sck = 1'b1;
      repeat (half) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic end_cs();
    repeat (half) @(negedge clk);
    cs = 1'b1;
    repeat (SYNC + 4) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; sck = 1'b0; cs = 1'b1; mosi = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_miso", miso, 0);
    chk("rst_miso_oe", miso_oe, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // single byte
    send_tx(8'hA5);
    chk("t1_tx_ready_low", tx_ready, 0);
    exp_miso.push_back(8'hA5);
    exp_rx.push_back(8'h3C);
    cs = 1'b0;
    repeat (6) @(negedge clk);
    chk("t1_miso_oe", miso_oe, 1);
    chk("t1_busy", busy, 1);
    chk("t1_tx_ready_after_load", tx_ready, 1);
    spi_byte(8'h3C);
    end_cs();
    chk("t1_rx_cnt", rx_cnt, 1);
    chk("t1_miso_oe_off", miso_oe, 0);

    // three-byte burst with underrun on the last byte
`ifdef SPI_RESP_UNDERRUN_EN
    ur_pulses = 0;
`endif
    send_tx(8'h01);
    exp_miso.push_back(8'h01); exp_miso.push_back(8'h02); exp_miso.push_back(8'hFF);
    exp_rx.push_back(8'h11); exp_rx.push_back(8'h22); exp_rx.push_back(8'h33);
    cs = 1'b0;
    fork
      begin
        spi_byte(8'h11);
        spi_byte(8'h22);
        spi_byte(8'h33);
      end
      begin
        repeat (40) @(negedge clk);
        send_tx(8'h02);
      end
    join
    end_cs();
    chk("t2_rx_cnt", rx_cnt, 4);
`ifdef SPI_RESP_UNDERRUN_EN
    chk("t2_ur_pulses", ur_pulses, 1);
    chk("t2_underrun_cnt", underrun_cnt, 1);
`endif

    // cs rises mid-byte
    cs = 1'b0;
    pulses(5);
    cs = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    chk("t3_miso_oe", miso_oe, 0);
    chk("t3_busy", busy, 0);
    chk("t3_rx_data_held", rx_data, 8'h33);
    chk("t3_rx_cnt", rx_cnt, 4);
    repeat (4) @(negedge clk);
    send_tx(8'h5A);
    exp_miso.push_back(8'h5A);
    exp_rx.push_back(8'hC3);
    cs = 1'b0;
    spi_byte(8'hC3);
    end_cs();
    chk("t3_rx_cnt_after", rx_cnt, 5);

    // sck activity with cs high
    pulses(8);
    repeat (SYNC + 4) @(negedge clk);
    chk("t4_rx_cnt", rx_cnt, 5);
    chk("t4_miso_oe", miso_oe, 0);
    chk("t4_busy", busy, 0);

    // reset mid-byte with a full holding register
    send_tx(8'h77);
    cs = 1'b0;
    repeat (12) @(negedge clk);
    send_tx(8'h88);
    chk("t5_hold_full", tx_ready, 0);
    pulses(3);
    rst_n = 1'b0; cs = 1'b1; sck = 1'b0;
    @(negedge clk);
    chk("t5_miso", miso, 0);
    chk("t5_miso_oe", miso_oe, 0);
    chk("t5_tx_ready", tx_ready, 1);
    chk("t5_rx_data", rx_data, 0);
    chk("t5_busy", busy, 0);
`ifdef SPI_RESP_UNDERRUN_EN
    chk("t5_underrun_cnt", underrun_cnt, 0);
`endif
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    exp_miso.push_back(8'hFF);
    exp_rx.push_back(8'h96);
    cs = 1'b0;
    spi_byte(8'h96);
    end_cs();
    chk("t5_rx_cnt", rx_cnt, 6);

`ifdef SPI_RESP_UNDERRUN_EN
    // saturation of the underrun counter
    cs = 1'b0;
    for (int i = 0; i < 260; i++) begin
      exp_miso.push_back(8'hFF);
      exp_rx.push_back(8'(i));
      spi_byte(8'(i));
    end
    end_cs();
    chk("t6_underrun_sat", underrun_cnt, 8'hFF);
    chk("t6_rx_cnt", rx_cnt, 266);
`endif

    chk("rx_queue_empty", exp_rx.size(), 0);
    chk("miso_queue_empty", exp_miso.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
